// File: rtl/pm_bus_arb.sv
`default_nettype none
// ============================================================================
// pm_bus_arb : program-memory bus arbiter, sequencer fetch vs. DAG data access
// Optional starvation limiter enabled by defining PM_ARB_STARVE_EN
// Revision : 1.0
// ============================================================================
module pm_bus_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps_arb_freq,
  input  logic [15:0] ps_arb_fadd,
  input  logic        dg_arb_dreq,
  input  logic        dg_arb_dwrb,
  input  logic [15:0] dg_arb_dadd,
  input  logic        ps_arb_idle,
  input  logic        ps_arb_wake,
  output logic        arb_pm_cslt,
  output logic        arb_pm_wrb,
  output logic [15:0] arb_pm_add,
  output logic        arb_ps_gnt,
  output logic        arb_dg_gnt,
  output logic        arb_ps_stall
);

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_DATA = 2'b01,
    S_HALT = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic        cslt_q, cslt_d;
  logic        wrb_q, wrb_d;
  logic [15:0] add_q, add_d;
  logic        ps_gnt_q, ps_gnt_d;
  logic        dg_gnt_q, dg_gnt_d;
  logic [15:0] replay_q, replay_d;
  logic        replay_vld_q, replay_vld_d;
  logic        stall_d;
  logic        fetch_pend;
  logic        limit_hit;

  // A displaced fetch stays owed to the sequencer until it is reissued.
  assign fetch_pend = ps_arb_freq | replay_vld_q;

`ifdef PM_ARB_STARVE_EN
  logic [1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (ps_gnt_d)
      starve_d = 2'd0;
    else if (dg_gnt_d && (starve_q != 2'd3))
      starve_d = starve_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= 2'd0;
    else      starve_q <= starve_d;
  end

  assign limit_hit = (starve_q == 2'd3) & fetch_pend;
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cslt_d       = 1'b0;
    wrb_d        = wrb_q;
    add_d        = add_q;
    ps_gnt_d     = 1'b0;
    dg_gnt_d     = 1'b0;
    replay_d     = replay_q;
    replay_vld_d = replay_vld_q;
    stall_d      = 1'b0;
    case (state_q)
      S_RUN, S_DATA: begin
        if (ps_arb_idle && !ps_arb_wake) begin
          // The access already on the bus finishes; nothing new is issued.
          state_d = S_HALT;
          stall_d = 1'b1;
        end else if (dg_arb_dreq && !limit_hit) begin
          state_d  = S_DATA;
          cslt_d   = 1'b1;
          wrb_d    = dg_arb_dwrb;
          add_d    = dg_arb_dadd;
          dg_gnt_d = 1'b1;
          stall_d  = ps_arb_freq;
          if (ps_arb_freq && !replay_vld_q) begin
            replay_d     = ps_arb_fadd;
            replay_vld_d = 1'b1;
          end
        end else begin
          state_d = S_RUN;
          if (fetch_pend) begin
            cslt_d       = 1'b1;
            wrb_d        = 1'b0;
            add_d        = replay_vld_q ? replay_q : ps_arb_fadd;
            ps_gnt_d     = 1'b1;
            replay_vld_d = 1'b0;
          end
        end
      end
      S_HALT: begin
        stall_d = 1'b1;
        if (ps_arb_wake) state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
        stall_d = ps_arb_freq;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RUN;
      cslt_q       <= 1'b0;
      wrb_q        <= 1'b0;
      add_q        <= 16'h0000;
      ps_gnt_q     <= 1'b0;
      dg_gnt_q     <= 1'b0;
      replay_q     <= 16'h0000;
      replay_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cslt_q       <= cslt_d;
      wrb_q        <= wrb_d;
      add_q        <= add_d;
      ps_gnt_q     <= ps_gnt_d;
      dg_gnt_q     <= dg_gnt_d;
      replay_q     <= replay_d;
      replay_vld_q <= replay_vld_d;
    end
  end

  assign arb_pm_cslt  = cslt_q;
  assign arb_pm_wrb   = wrb_q;
  assign arb_pm_add   = add_q;
  assign arb_ps_gnt   = ps_gnt_q;
  assign arb_dg_gnt   = dg_gnt_q;
  // Stall is combinational, so it must be forced low while reset is held.
  assign arb_ps_stall = rst & stall_d;

endmodule
`default_nettype wire

// File: tb/tb_pm_bus_arb.sv
`default_nettype none
// ============================================================================
// tb_pm_bus_arb : randomized self-checking bench for pm_bus_arb
// Revision : 1.0
// ============================================================================
module tb_pm_bus_arb;

`ifdef PM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freq = 1'b0, dreq = 1'b0, dwrb = 1'b0, idle = 1'b0, wake = 1'b0;
  logic [15:0] fadd = 16'h0, dadd = 16'h0;
  logic        cslt, wrb, ps_gnt, dg_gnt, stall;
  logic [15:0] add;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pm_bus_arb u_dut (
    .clk          (clk),
    .rst          (rst),
    .ps_arb_freq  (freq),
    .ps_arb_fadd  (fadd),
    .dg_arb_dreq  (dreq),
    .dg_arb_dwrb  (dwrb),
    .dg_arb_dadd  (dadd),
    .ps_arb_idle  (idle),
    .ps_arb_wake  (wake),
    .arb_pm_cslt  (cslt),
    .arb_pm_wrb   (wrb),
    .arb_pm_add   (add),
    .arb_ps_gnt   (ps_gnt),
    .arb_dg_gnt   (dg_gnt),
    .arb_ps_stall (stall)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: priority rules over a queue of owed fetches and an
  // unbounded count of DAG grants since the last fetch.
  bit          m_halted;
  int          m_streak;
  logic [15:0] m_owed[$];
  logic        m_cslt, m_wrb, m_psg, m_dgg, m_stall;
  logic [15:0] m_add;
  int          n_dag, n_fetch;

  task automatic model_reset();
    m_halted = 0; m_streak = 0; m_owed.delete();
    m_cslt = 0; m_wrb = 0; m_add = 16'h0; m_psg = 0; m_dgg = 0; m_stall = 0;
  endtask

  task automatic model_eval();
    bit want_fetch;
    bit yield;
    want_fetch = freq || (m_owed.size() > 0);
    yield      = STARVE && (m_streak >= 3) && want_fetch;
    m_cslt = 0; m_psg = 0; m_dgg = 0; m_stall = 0;
    if (m_halted) begin
      m_stall = 1;
      if (wake) m_halted = 0;
    end else if (idle && !wake) begin
      m_stall  = 1;
      m_halted = 1;
    end else if (dreq && !yield) begin
      m_cslt = 1; m_wrb = dwrb; m_add = dadd; m_dgg = 1;
      m_stall = freq;
      if (freq && m_owed.size() == 0) m_owed.push_back(fadd);
      m_streak++;
    end else if (want_fetch) begin
      m_cslt = 1; m_wrb = 0; m_psg = 1;
      m_add = (m_owed.size() > 0) ? m_owed.pop_front() : fadd;
      m_streak = 0;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic run_cycle();
    #2;
    model_eval();
    check_val("stall", stall, m_stall);
    @(posedge clk);
    #1;
    check_val("cslt", cslt, m_cslt);
    check_val("wrb", wrb, m_wrb);
    check_val("add", add, m_add);
    check_val("ps_gnt", ps_gnt, m_psg);
    check_val("dg_gnt", dg_gnt, m_dgg);
    check_val("gnt_excl", ps_gnt & dg_gnt, 1'b0);
    if (dg_gnt) n_dag++;
    if (ps_gnt) n_fetch++;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    freq = 0; fadd = 0; dreq = 0; dwrb = 0; dadd = 0; idle = 0; wake = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_cslt"}, cslt, 1'b0);
    check_val({tag, "_wrb"}, wrb, 1'b0);
    check_val({tag, "_add"}, add, 16'h0);
    check_val({tag, "_gnt"}, {ps_gnt, dg_gnt}, 2'b00);
    check_val({tag, "_stall"}, stall, 1'b0);
  endtask

  initial begin
    model_reset();
    clear_inputs();
    freq = 1; fadd = 16'hBEEF;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1;

    // Straight fetch stream
    for (int i = 0; i < 4; i++) begin
      freq = 1; fadd = 16'h0010 + 16'(i);
      run_cycle();
    end

    // Single read collision, sequencer holds its address while stalled
    freq = 1; fadd = 16'h0020; dreq = 1; dwrb = 0; dadd = 16'h1234;
    run_cycle();
    dreq = 0;
    run_cycle();
    fadd = 16'h0021;
    run_cycle();

    // Long DAG burst against a waiting fetch
    n_dag = 0; n_fetch = 0;
    freq = 1; fadd = 16'h0030; dreq = 1; dwrb = 1; dadd = 16'h4000;
    for (int i = 0; i < 6; i++) begin
      dadd = 16'h4000 + 16'(i);
      run_cycle();
    end
    check_val("burst_dag", n_dag, STARVE ? 5 : 6);
    check_val("burst_fetch", n_fetch, STARVE ? 1 : 0);
    dreq = 0;
    run_cycle();

    // IDLE during an in-flight DAG write, then wake
    freq = 0; dreq = 1; dwrb = 1; dadd = 16'h00FF;
    run_cycle();
    check_val("idle_wr", {cslt, wrb, add}, {1'b1, 1'b1, 16'h00FF});
    dreq = 0; idle = 1;
    run_cycle();
    idle = 0; dreq = 1; dadd = 16'h0ABC; freq = 1; fadd = 16'h0040;
    repeat (3) run_cycle();
    check_val("halt_cslt", cslt, 1'b0);
    dreq = 0; wake = 1;
    run_cycle();
    wake = 0;
    run_cycle();
    check_val("wake_fetch", {ps_gnt, add}, {1'b1, 16'h0040});

    // Idle and wake together: wake wins, no halt
    idle = 1; wake = 1; freq = 1; fadd = 16'h0050;
    run_cycle();
    idle = 0; wake = 0;

    // Reset in the middle of a DAG burst
    freq = 1; fadd = 16'h0060; dreq = 1; dadd = 16'h7777;
    run_cycle();
    #1;
    rst = 0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1;
    freq = 1; fadd = 16'h0000;
    run_cycle();
    check_val("postrst_fetch", {cslt, ps_gnt, add}, {1'b1, 1'b1, 16'h0000});

    // Randomized traffic with protocol-respecting holds
    for (int i = 0; i < 600; i++) begin
      if (!(freq && m_stall)) begin
        freq = ($urandom_range(0, 9) < 7);
        fadd = 16'($urandom);
      end
      if (!(dreq && !m_dgg) || $urandom_range(0, 9) == 0) begin
        dreq = ($urandom_range(0, 9) < 4);
        dwrb = 1'($urandom);
        dadd = 16'($urandom);
      end
      idle = ($urandom_range(0, 39) == 0);
      wake = m_halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
